// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Memory stage: variable-latency data-memory access, stall control and MEM/WB register
module memory_stage #(
  parameter int WORD     = 32,
  parameter int REG_SIZE = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [WORD-1:0]     writeDataM,
  input  logic [WORD-1:0]     ALUResultM,
  input  logic [WORD-1:0]     pcM,
  input  logic [REG_SIZE-1:0] writeRegM,
  input  logic                regWriteM,
  input  logic                memWriteM,
  input  logic                mem2regM,
  input  logic                finishM,
  input  logic                validM,
  output logic                memReq,
  output logic                memWe,
  output logic [WORD-1:0]     memAddr,
  output logic [WORD-1:0]     memWData,
  input  logic                memAck,
  input  logic [WORD-1:0]     memRData,
  output logic                stallM,
  output logic [WORD-1:0]     resultW,
  output logic [WORD-1:0]     pcW,
  output logic [REG_SIZE-1:0] writeRegW,
  output logic                regWriteW,
  output logic                finishW,
  output logic                validW,
  output logic                memErrW
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t          r_state;
  logic [7:0]      r_cnt;
  logic [WORD-1:0] r_rbuf;
  logic            r_ebuf;

  logic            w_mop;
  logic            w_load;
  logic [WORD-1:0] w_result;
  logic            w_err;

  assign w_mop    = validM & (memWriteM | mem2regM);
  assign memAddr  = ALUResultM;
  assign memWData = writeDataM;
  assign memWe    = memWriteM;

  // Request and stall are gated by reset so a pending access is dropped in the reset cycle itself.
  assign memReq = reset & (((r_state == IDLE) & w_mop) | (r_state == WAIT));
  assign stallM = reset & (((r_state == IDLE) & w_mop & ~memAck) | (r_state == WAIT));

  always_comb begin
    w_load   = 1'b0;
    w_result = ALUResultM;
    w_err    = 1'b0;
    case (r_state)
      IDLE: begin
        w_load   = en & (~w_mop | memAck);
        w_result = (w_mop & mem2regM) ? memRData : ALUResultM;
      end
      HOLD: begin
        w_load   = en;
        w_result = mem2regM ? r_rbuf : ALUResultM;
        w_err    = r_ebuf;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_rbuf  <= '0;
      r_ebuf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mop && memAck && !en) begin
            r_rbuf  <= memRData;
            r_ebuf  <= 1'b0;
            r_state <= HOLD;
          end else if (w_mop && !memAck) begin
            r_cnt   <= 8'd1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (memAck) begin
            r_rbuf  <= memRData;
            r_ebuf  <= 1'b0;
            r_state <= HOLD;
          end else if (r_cnt == 8'(MAX_WAIT)) begin
            r_rbuf  <= '0;
            r_ebuf  <= 1'b1;
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (en) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // MEM/WB register; an abandoned access never writes the register file.
  always_ff @(posedge clk) begin
    if (!reset) begin
      resultW   <= '0;
      pcW       <= '0;
      writeRegW <= '0;
      regWriteW <= 1'b0;
      finishW   <= 1'b0;
      validW    <= 1'b0;
      memErrW   <= 1'b0;
    end else if (w_load) begin
      resultW   <= w_result;
      pcW       <= pcM;
      writeRegW <= writeRegM;
      regWriteW <= regWriteM & ~w_err;
      finishW   <= finishM;
      validW    <= validM;
      memErrW   <= w_err;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - Directed self-checking bench for memory_stage
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] writeDataM, ALUResultM, pcM;
  logic [4:0]  writeRegM;
  logic        regWriteM, memWriteM, mem2regM, finishM, validM;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWData;
  logic        memAck;
  logic [31:0] memRData;
  logic        stallM;
  logic [31:0] resultW, pcW;
  logic [4:0]  writeRegW;
  logic        regWriteW, finishW, validW, memErrW;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls, reqs, addr_bad, req_bad;

  memory_stage #(.WORD(32), .REG_SIZE(5), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .en(en),
    .writeDataM(writeDataM), .ALUResultM(ALUResultM), .pcM(pcM),
    .writeRegM(writeRegM), .regWriteM(regWriteM), .memWriteM(memWriteM),
    .mem2regM(mem2regM), .finishM(finishM), .validM(validM),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memAck(memAck), .memRData(memRData), .stallM(stallM),
    .resultW(resultW), .pcW(pcW), .writeRegW(writeRegW), .regWriteW(regWriteW),
    .finishW(finishW), .validW(validW), .memErrW(memErrW)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    en = 1'b1; writeDataM = '0; ALUResultM = '0; pcM = '0; writeRegM = '0;
    regWriteM = 1'b0; memWriteM = 1'b0; mem2regM = 1'b0; finishM = 1'b0;
    validM = 1'b0; memAck = 1'b0; memRData = '0;
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] pc);
    set_idle();
    validM = 1'b1; mem2regM = 1'b1; regWriteM = 1'b1;
    ALUResultM = addr; writeRegM = rd; pcM = pc;
  endtask

  initial begin
    // Reset held for two edges with a memory op presented
    reset = 1'b0;
    set_load(32'h200, 5'd3, 32'h10);
    tick();
    tick();
    check_eq("rst_memReq", 32'(memReq), 32'd0);
    check_eq("rst_stallM", 32'(stallM), 32'd0);
    check_eq("rst_resultW", resultW, 32'd0);
    check_eq("rst_validW", 32'(validW), 32'd0);
    check_eq("rst_memErrW", 32'(memErrW), 32'd0);
    check_eq("rst_writeRegW", 32'(writeRegW), 32'd0);
    check_eq("rst_pcW", pcW, 32'd0);
    reset = 1'b1;
    set_idle();
    tick();

    // Plain ALU op
    set_idle();
    validM = 1'b1; regWriteM = 1'b1; ALUResultM = 32'h1234; writeRegM = 5'd5; pcM = 32'h40;
    #1;
    check_eq("alu_memReq", 32'(memReq), 32'd0);
    check_eq("alu_stallM", 32'(stallM), 32'd0);
    tick();
    check_eq("alu_resultW", resultW, 32'h1234);
    check_eq("alu_writeRegW", 32'(writeRegW), 32'd5);
    check_eq("alu_validW", 32'(validW), 32'd1);
    check_eq("alu_regWriteW", 32'(regWriteW), 32'd1);
    check_eq("alu_pcW", pcW, 32'h40);

    // Load acked in the 3rd cycle after request
    set_load(32'h200, 5'd7, 32'h44);
    stalls = 0; addr_bad = 0; req_bad = 0;
    for (int c = 1; c <= 3; c++) begin
      memAck = (c == 3);
      memRData = (c == 3) ? 32'hDEADBEEF : 32'h0;
      #1;
      if (stallM) stalls++;
      if (memAddr !== 32'h200) addr_bad++;
      if (!memReq) req_bad++;
      tick();
    end
    memAck = 1'b0; memRData = 32'h0;
    #1;
    if (stallM) stalls++;
    check_eq("ld_hold_memReq", 32'(memReq), 32'd0);
    check_eq("ld_hold_resultW", resultW, 32'h1234);
    tick();
    set_idle();
    check_eq("ld_stall_cycles", 32'(stalls), 32'd3);
    check_eq("ld_addr_unstable", 32'(addr_bad), 32'd0);
    check_eq("ld_req_gap", 32'(req_bad), 32'd0);
    check_eq("ld_resultW", resultW, 32'hDEADBEEF);
    check_eq("ld_memErrW", 32'(memErrW), 32'd0);
    check_eq("ld_writeRegW", 32'(writeRegW), 32'd7);
    check_eq("ld_regWriteW", 32'(regWriteW), 32'd1);

    // Zero-wait store with MEM/WB frozen for two cycles after the ack
    set_idle();
    validM = 1'b1; memWriteM = 1'b1; writeDataM = 32'hA5A5A5A5; ALUResultM = 32'h100;
    pcM = 32'h80; en = 1'b0; memAck = 1'b1;
    #1;
    check_eq("st_memReq", 32'(memReq), 32'd1);
    check_eq("st_memWe", 32'(memWe), 32'd1);
    check_eq("st_memWData", memWData, 32'hA5A5A5A5);
    check_eq("st_stallM", 32'(stallM), 32'd0);
    reqs = 1;
    tick();
    memAck = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (memReq) reqs++;
      check_eq("st_frozen_resultW", resultW, 32'hDEADBEEF);
      check_eq("st_hold_stallM", 32'(stallM), 32'd0);
      if (c == 1) en = 1'b1;
      tick();
    end
    set_idle();
    check_eq("st_req_cycles", 32'(reqs), 32'd1);
    check_eq("st_resultW", resultW, 32'h100);
    check_eq("st_regWriteW", 32'(regWriteW), 32'd0);
    check_eq("st_validW", 32'(validW), 32'd1);
    check_eq("st_pcW", pcW, 32'h80);

    // Load with no ack: timeout after MAX_WAIT
    set_load(32'h300, 5'd9, 32'hC0);
    stalls = 0;
    for (int c = 1; c <= 17; c++) begin
      #1;
      if (stallM) stalls++;
      if (c == 17) check_eq("to_hold_memReq", 32'(memReq), 32'd0);
      tick();
    end
    set_idle();
    check_eq("to_stall_cycles", 32'(stalls), 32'd16);
    check_eq("to_resultW", resultW, 32'd0);
    check_eq("to_memErrW", 32'(memErrW), 32'd1);
    check_eq("to_regWriteW", 32'(regWriteW), 32'd0);
    check_eq("to_writeRegW", 32'(writeRegW), 32'd9);
    check_eq("to_validW", 32'(validW), 32'd1);

    // Reset in the second WAIT cycle, then a stale ack
    set_load(32'h400, 5'd11, 32'hD0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("rw_memReq", 32'(memReq), 32'd0);
    check_eq("rw_stallM", 32'(stallM), 32'd0);
    tick();
    reset = 1'b1;
    set_idle();
    memAck = 1'b1; memRData = 32'h12345678;
    #1;
    check_eq("rw_late_memReq", 32'(memReq), 32'd0);
    check_eq("rw_resultW", resultW, 32'd0);
    check_eq("rw_validW", 32'(validW), 32'd0);
    check_eq("rw_memErrW", 32'(memErrW), 32'd0);
    tick();
    memAck = 1'b0; memRData = 32'h0;
    check_eq("rw_after_resultW", resultW, 32'd0);
    check_eq("rw_after_validW", 32'(validW), 32'd0);
    set_load(32'h500, 5'd2, 32'hE0);
    #1;
    check_eq("rw_idle_stallM", 32'(stallM), 32'd1);
    check_eq("rw_idle_memReq", 32'(memReq), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
